// File: rtl/traffic_pkg.sv
// Shared phase-state enum and lamp encoding for the traffic signal controller.
// The WALK phase value exists in every build but is reachable only with TRAFFIC_PED_WALK_EN.
package traffic_pkg;

   typedef enum logic [1:0] {
      GREEN  = 2'd0,
      YELLOW = 2'd1,
      ALLRED = 2'd2,
      WALK   = 2'd3
   } phase_t;

   localparam logic [2:0] LAMP_RED    = 3'b001;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b100;

   // Lamp shown by the approach owning right-of-way in a given phase.
   function automatic logic [2:0] lamp_of(input phase_t ph);
      case (ph)
         GREEN:   lamp_of = LAMP_GREEN;
         YELLOW:  lamp_of = LAMP_YELLOW;
         default: lamp_of = LAMP_RED;
      endcase
   endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Round-robin search: first set bit of req starting at cur+1, wrapping, cur itself last.
// next holds cur when no request is pending.
module rr_next_dir
   import traffic_pkg::*;
#(
   parameter int NUM_DIR = 4,
   parameter int DIR_W   = $clog2(NUM_DIR)
) (
   input  logic [NUM_DIR-1:0] req,
   input  logic [DIR_W-1:0]   cur,
   output logic [DIR_W-1:0]   next,
   output logic               any_valid
);

   logic [DIR_W:0] idx;

   always_comb begin
      next      = cur;
      any_valid = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NUM_DIR; k++) begin
         idx = {1'b0, cur} + (DIR_W+1)'(k);
         if (idx >= (DIR_W+1)'(NUM_DIR)) idx = idx - (DIR_W+1)'(NUM_DIR);
         if (!any_valid && req[idx[DIR_W-1:0]]) begin
            any_valid = 1'b1;
            next      = idx[DIR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/traffic_signal_ctrl.sv
// Multi-approach traffic signal controller: GREEN -> YELLOW -> ALLRED -> next GREEN, demand driven.
// Optional pedestrian WALK phase compiled in with `define TRAFFIC_PED_WALK_EN.
module traffic_signal_ctrl
   import traffic_pkg::*;
#(
   parameter int NUM_DIR   = 4,
   parameter int MIN_GREEN = 5,
   parameter int MAX_GREEN = 20,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 1,
   parameter int TMR_W     = 8
`ifdef TRAFFIC_PED_WALK_EN
   ,
   parameter int WALK_T    = 6
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic [NUM_DIR-1:0]         sensor,
`ifdef TRAFFIC_PED_WALK_EN
   input  logic                       ped_req,
   output logic                       walk,
`endif
   output logic [NUM_DIR-1:0]         green,
   output logic [NUM_DIR-1:0]         yellow,
   output logic [NUM_DIR-1:0]         red,
   output logic [$clog2(NUM_DIR)-1:0] active_dir
);

   localparam int DIR_W = $clog2(NUM_DIR);

   if (NUM_DIR < 2 || NUM_DIR > 8 || MIN_GREEN < 1 || MIN_GREEN > MAX_GREEN ||
       MAX_GREEN >= 2**TMR_W || YELLOW_T < 1 || ALLRED_T < 1 ||
       YELLOW_T > 2**TMR_W || ALLRED_T > 2**TMR_W) begin : g_param_err
      $error("traffic_signal_ctrl: illegal parameter combination");
   end

   phase_t               state, state_nx;
   logic [TMR_W-1:0]     timer, timer_nx;
   logic [TMR_W:0]       timer_inc;
   logic [NUM_DIR-1:0]   req, req_nx;
   logic [DIR_W-1:0]     dir_nx, rr_dir;
   logic                 rr_any;
   logic                 competing;
   logic                 entering_green;
   logic [NUM_DIR-1:0]   green_nx, yellow_nx, red_nx;
`ifdef TRAFFIC_PED_WALK_EN
   logic                 ped_pend, ped_pend_nx, walk_nx;
`endif

   rr_next_dir #(
      .NUM_DIR (NUM_DIR),
      .DIR_W   (DIR_W)
   ) u_rr (
      .req       (req),
      .cur       (active_dir),
      .next      (rr_dir),
      .any_valid (rr_any)
   );

   assign timer_inc = {1'b0, timer} + 1'b1;

`ifdef TRAFFIC_PED_WALK_EN
   assign competing = (|(req & ~(NUM_DIR'(1) << active_dir))) | ped_pend;
`else
   assign competing = |(req & ~(NUM_DIR'(1) << active_dir));
`endif

   // State register; lamps are registered from the next-state view so they track the phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= GREEN;
         active_dir <= '0;
         timer      <= '0;
         req        <= '0;
         green      <= NUM_DIR'(1);
         yellow     <= '0;
         red        <= ~(NUM_DIR'(1));
`ifdef TRAFFIC_PED_WALK_EN
         ped_pend   <= 1'b0;
         walk       <= 1'b0;
`endif
      end else begin
         state      <= state_nx;
         active_dir <= dir_nx;
         timer      <= timer_nx;
         req        <= req_nx;
         green      <= green_nx;
         yellow     <= yellow_nx;
         red        <= red_nx;
`ifdef TRAFFIC_PED_WALK_EN
         ped_pend   <= ped_pend_nx;
         walk       <= walk_nx;
`endif
      end
   end

   // Next-state, timer and request bookkeeping.
   always_comb begin
      state_nx = state;
      dir_nx   = active_dir;
      if (tick) begin
         case (state)
            GREEN:
               if (competing &&
                   ((timer_inc >= (TMR_W+1)'(MIN_GREEN) && !sensor[active_dir]) ||
                    timer_inc >= (TMR_W+1)'(MAX_GREEN)))
                  state_nx = YELLOW;
            YELLOW:
               if (timer_inc == (TMR_W+1)'(YELLOW_T)) state_nx = ALLRED;
            ALLRED:
               if (timer_inc == (TMR_W+1)'(ALLRED_T)) begin
`ifdef TRAFFIC_PED_WALK_EN
                  if (ped_pend) begin
                     state_nx = WALK;
                  end else begin
                     state_nx = GREEN;
                     dir_nx   = rr_any ? rr_dir : active_dir;
                  end
`else
                  state_nx = GREEN;
                  dir_nx   = rr_any ? rr_dir : active_dir;
`endif
               end
`ifdef TRAFFIC_PED_WALK_EN
            WALK:
               if (timer_inc == (TMR_W+1)'(WALK_T)) state_nx = ALLRED;
`endif
            default: state_nx = GREEN;
         endcase
      end

      timer_nx = timer;
      if (tick) begin
         if (state_nx != state)
            timer_nx = '0;
         else if (state == GREEN && timer_inc > (TMR_W+1)'(MAX_GREEN))
            timer_nx = TMR_W'(MAX_GREEN);
         else
            timer_nx = timer_inc[TMR_W-1:0];
      end

      // The approach being granted green loses its request even if its sensor is high now.
      entering_green = (state != GREEN) && (state_nx == GREEN);
      req_nx = req | sensor;
      if (entering_green) req_nx = req_nx & ~(NUM_DIR'(1) << dir_nx);

`ifdef TRAFFIC_PED_WALK_EN
      ped_pend_nx = ped_pend | ped_req;
      if (state != WALK && state_nx == WALK) ped_pend_nx = 1'b0;
`endif
   end

   // Lamp decode for the upcoming cycle.
   always_comb begin
      logic [2:0] lamp;
      green_nx  = '0;
      yellow_nx = '0;
      red_nx    = '0;
      lamp      = LAMP_RED;
      for (int i = 0; i < NUM_DIR; i++) begin
         lamp         = (DIR_W'(i) == dir_nx) ? lamp_of(state_nx) : LAMP_RED;
         green_nx[i]  = (lamp == LAMP_GREEN);
         yellow_nx[i] = (lamp == LAMP_YELLOW);
         red_nx[i]    = (lamp == LAMP_RED);
      end
`ifdef TRAFFIC_PED_WALK_EN
      walk_nx = (state_nx == WALK);
`endif
   end

endmodule

// File: tb/tb_traffic_signal_ctrl.sv
// Scoreboard bench for traffic_signal_ctrl (default build, pedestrian phase not compiled).
// A cycle model queues expected lamps/active_dir at each edge; a checker pops them 1 time unit later.
module tb_traffic_signal_ctrl;

   localparam int N     = 4;
   localparam int MIN_G = 3;
   localparam int MAX_G = 8;
   localparam int YEL   = 2;
   localparam int AR    = 1;
   localparam int TW    = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tick = 1'b1;
   logic [N-1:0] sensor = '0;
   logic [N-1:0] green, yellow, red;
   logic [1:0]   active_dir;

   traffic_signal_ctrl #(
      .NUM_DIR   (N),
      .MIN_GREEN (MIN_G),
      .MAX_GREEN (MAX_G),
      .YELLOW_T  (YEL),
      .ALLRED_T  (AR),
      .TMR_W     (TW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .sensor     (sensor),
      .green      (green),
      .yellow     (yellow),
      .red        (red),
      .active_dir (active_dir)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] g;
      logic [N-1:0] y;
      logic [N-1:0] r;
      logic [1:0]   d;
   } exp_t;

   exp_t         sb_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           m_st  = 0;   // 0 green, 1 yellow, 2 all-red
   int           m_t   = 0;
   int           m_dir = 0;
   logic [N-1:0] m_req = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   // Reference model: advance one clock edge and queue the expected registered outputs.
   always @(posedge clk) begin : p_model
      int           nst, ndir, nt, t1;
      logic [N-1:0] nreq;
      logic         comp;
      exp_t         e;
      if (rst) begin
         nst = 0; ndir = 0; nt = 0; nreq = '0;
      end else begin
         nst = m_st; ndir = m_dir; nt = m_t; t1 = m_t + 1;
         comp = 1'b0;
         for (int j = 0; j < N; j++)
            if (j != m_dir && m_req[j]) comp = 1'b1;
         if (tick) begin
            case (m_st)
               0: if (comp && ((t1 >= MIN_G && !sensor[m_dir]) || t1 >= MAX_G)) nst = 1;
               1: if (t1 == YEL) nst = 2;
               default:
                  if (t1 == AR) begin
                     nst = 0;
                     for (int k = N; k >= 1; k--)
                        if (m_req[(m_dir + k) % N]) ndir = (m_dir + k) % N;
                  end
            endcase
            if (nst != m_st)                nt = 0;
            else if (m_st == 0 && t1 > MAX_G) nt = MAX_G;
            else                            nt = t1;
         end
         nreq = m_req | sensor;
         if (m_st != 0 && nst == 0) nreq[ndir] = 1'b0;
      end
      m_st = nst; m_dir = ndir; m_t = nt; m_req = nreq;
      e.g = (nst == 0) ? (N'(1) << ndir) : '0;
      e.y = (nst == 1) ? (N'(1) << ndir) : '0;
      e.r = ~(e.g | e.y);
      e.d = 2'(ndir);
      sb_q.push_back(e);
   end

   always @(posedge clk) begin : p_check
      exp_t e;
      #1;
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 32'(0), 32'(1));
      end else begin
         e = sb_q.pop_front();
         chk("green",      32'(green),      32'(e.g));
         chk("yellow",     32'(yellow),     32'(e.y));
         chk("red",        32'(red),        32'(e.r));
         chk("active_dir", 32'(active_dir), 32'(e.d));
      end
   end

   // Hold inputs through one active edge; returns at the following negedge.
   task automatic cyc(input logic [N-1:0] s, input int n, input logic tk = 1'b1);
      repeat (n) begin
         sensor = s;
         tick   = tk;
         @(negedge clk);
      end
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_green"},  32'(green),      32'(4'b0001));
      chk({tag, "_yellow"}, 32'(yellow),     32'(4'b0000));
      chk({tag, "_red"},    32'(red),        32'(4'b1110));
      chk({tag, "_dir"},    32'(active_dir), 32'(0));
   endtask

   // Reset with all sensors high and tick asserted: reset must win.
   task automatic do_reset(input string tag);
      rst = 1'b1; tick = 1'b1; sensor = '1;
      @(negedge clk);
      rst = 1'b0; sensor = '0;
      reset_check(tag);
   endtask

   initial begin
      int waited;
      rst = 1'b1; tick = 1'b1; sensor = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      reset_check("por");

      // Idle: approach 0 rests in green.
      cyc('0, 50);

      // Single competing request with the green approach empty.
      do_reset("rst_a");
      cyc(4'b0100, 1);
      cyc('0, 12);

      // Occupied green approach holds until MAX_GREEN, then approach 1.
      do_reset("rst_b");
      cyc(4'b0011, 1);
      cyc(4'b0001, 15);
      cyc('0, 8);

      // Move to approach 2, then requests on 1 and 3 must be served 3 then 1.
      cyc(4'b0100, 1);
      cyc('0, 6);
      cyc(4'b1010, 1);
      cyc('0, 30);

      // Long occupied green: timer saturates, so a late request exits at once.
      do_reset("rst_c");
      cyc(4'b0001, 300);
      cyc(4'b0011, 1);
      cyc('0, 10);

      // Random sensors with an irregular tick.
      repeat (400)
         cyc(N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)), 1, 1'($urandom_range(0, 1)));
      cyc('0, 20);

      // Reset in the middle of approach 2's yellow with other requests pending.
      do_reset("rst_d");
      cyc(4'b0100, 1);
      waited = 0;
      while (!(m_st == 1 && m_dir == 2) && waited < 60) begin
         cyc(4'b0011, 1);
         waited++;
      end
      chk("reach_yellow2", 32'(waited < 60), 32'(1));
      do_reset("rst_mid_yellow");
      cyc('0, 20);

      chk("sb_drain", 32'(sb_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
